// File: rtl/mc_control_fsm_if.sv
// Handshake and datapath-control bundle between mc_control_fsm (master) and the
// memories / register file / ALU / PC datapath (slave).
interface mc_control_fsm_if;
    logic [31:0] instr;
    logic        imem_ack;
    logic        dmem_ack;
    logic        zero;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_write;
    logic [4:0]  opcode_ULA;
    logic        alu_src_imm;
    logic        reg_write;
    logic        reg_dst_rd;
    logic        mem_to_reg;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        halted;
    logic        illegal;
    logic        bus_error;

    modport master (
        input  instr, imem_ack, dmem_ack, zero,
        output imem_req, dmem_req, dmem_we, ir_write, opcode_ULA, alu_src_imm,
               reg_write, reg_dst_rd, mem_to_reg, pc_write, pc_src,
               halted, illegal, bus_error
    );

    modport slave (
        output instr, imem_ack, dmem_ack, zero,
        input  imem_req, dmem_req, dmem_we, ir_write, opcode_ULA, alu_src_imm,
               reg_write, reg_dst_rd, mem_to_reg, pc_write, pc_src,
               halted, illegal, bus_error
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-variant control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer.
// Define MC_CTRL_ILLEGAL_TRAP_EN to halt on an undefined opcode instead of skipping it.
module mc_control_fsm #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input logic              clock,
    input logic              reset,
    mc_control_fsm_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [2:0] {
        CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_HALT, CLS_ILLEGAL
    } cls_t;

    state_t      state;
    cls_t        cls;
    cls_t        dec_cls;
    logic [31:0] ir;
    logic [31:0] wait_cnt;
    logic [4:0]  dec_alu_op;
    logic        dec_imm;
    logic        dec_rd;
    logic        dec_m2r;
    logic        timeout_hit;
    logic        branch_taken;
    logic        unused_fields;

    logic        imem_req_r;
    logic        dmem_req_r;
    logic        dmem_we_r;
    logic        ir_write_r;
    logic [4:0]  opcode_r;
    logic        alu_src_imm_r;
    logic        reg_write_r;
    logic        reg_dst_rd_r;
    logic        mem_to_reg_r;
    logic        pc_write_r;
    logic [1:0]  pc_src_r;
    logic        halted_r;
    logic        illegal_r;
    logic        bus_error_r;

    // Register numbers are routed by the datapath; control only needs op and funct.
    assign unused_fields = ^ir[25:5];

    always_comb begin
        dec_cls    = CLS_ILLEGAL;
        dec_alu_op = 5'd0;
        dec_imm    = 1'b0;
        dec_rd     = 1'b0;
        dec_m2r    = 1'b0;
        if (ir[31:26] == 6'h00) begin
            dec_cls    = CLS_ALU;
            dec_alu_op = ir[4:0];
            dec_rd     = 1'b1;
        end else if (ir[31]) begin
            dec_cls    = CLS_ALU;
            dec_alu_op = ir[30:26];
            dec_imm    = 1'b1;
        end else begin
            case (ir[31:26])
                6'h02: begin
                    dec_cls    = CLS_LOAD;
                    dec_alu_op = 5'b00100;
                    dec_imm    = 1'b1;
                    dec_m2r    = 1'b1;
                end
                6'h03: begin
                    dec_cls    = CLS_STORE;
                    dec_alu_op = 5'b00100;
                    dec_imm    = 1'b1;
                end
                6'h04: begin
                    dec_cls    = CLS_BRANCH;
                    dec_alu_op = 5'b10000;
                end
                6'h05: begin
                    dec_cls    = CLS_BRANCH;
                    dec_alu_op = 5'b10001;
                end
                6'h06:   dec_cls = CLS_JUMP;
                6'h07:   dec_cls = CLS_HALT;
                default: dec_cls = CLS_ILLEGAL;
            endcase
        end
    end

    // An ack seen in the expiry cycle takes priority over the timeout.
    assign timeout_hit  = (ACK_TIMEOUT != 0) && (wait_cnt == ACK_TIMEOUT - 32'd1);
    assign branch_taken = (state == EXEC) && (cls == CLS_BRANCH) && bus.zero;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= FETCH;
            cls           <= CLS_ALU;
            ir            <= '0;
            wait_cnt      <= '0;
            imem_req_r    <= 1'b0;
            dmem_req_r    <= 1'b0;
            dmem_we_r     <= 1'b0;
            ir_write_r    <= 1'b0;
            opcode_r      <= '0;
            alu_src_imm_r <= 1'b0;
            reg_write_r   <= 1'b0;
            reg_dst_rd_r  <= 1'b0;
            mem_to_reg_r  <= 1'b0;
            pc_write_r    <= 1'b0;
            pc_src_r      <= 2'b00;
            halted_r      <= 1'b0;
            illegal_r     <= 1'b0;
            bus_error_r   <= 1'b0;
        end else begin
            ir_write_r  <= 1'b0;
            pc_write_r  <= 1'b0;
            reg_write_r <= 1'b0;
            case (state)
                FETCH: begin
                    if (!imem_req_r) begin
                        // First cycle out of reset: raise the request.
                        imem_req_r <= 1'b1;
                        wait_cnt   <= '0;
                    end else if (bus.imem_ack) begin
                        imem_req_r <= 1'b0;
                        ir         <= bus.instr;
                        ir_write_r <= 1'b1;
                        pc_write_r <= 1'b1;
                        pc_src_r   <= 2'b00;
                        state      <= DECODE;
                    end else if (timeout_hit) begin
                        imem_req_r  <= 1'b0;
                        bus_error_r <= 1'b1;
                        halted_r    <= 1'b1;
                        state       <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DECODE: begin
                    cls           <= dec_cls;
                    opcode_r      <= dec_alu_op;
                    alu_src_imm_r <= dec_imm;
                    reg_dst_rd_r  <= dec_rd;
                    mem_to_reg_r  <= dec_m2r;
                    case (dec_cls)
                        CLS_JUMP: begin
                            pc_write_r <= 1'b1;
                            pc_src_r   <= 2'b10;
                            imem_req_r <= 1'b1;
                            wait_cnt   <= '0;
                            state      <= FETCH;
                        end
                        CLS_HALT: begin
                            halted_r <= 1'b1;
                            state    <= HALT;
                        end
                        CLS_ILLEGAL: begin
                            illegal_r <= 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                            halted_r  <= 1'b1;
                            state     <= HALT;
`else
                            imem_req_r <= 1'b1;
                            wait_cnt   <= '0;
                            state      <= FETCH;
`endif
                        end
                        default: state <= EXEC;
                    endcase
                end
                EXEC: begin
                    case (cls)
                        CLS_BRANCH: begin
                            imem_req_r <= 1'b1;
                            wait_cnt   <= '0;
                            state      <= FETCH;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            dmem_req_r <= 1'b1;
                            dmem_we_r  <= (cls == CLS_STORE);
                            wait_cnt   <= '0;
                            state      <= MEM;
                        end
                        default: begin
                            reg_write_r <= 1'b1;
                            state       <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        if (cls == CLS_LOAD) begin
                            reg_write_r <= 1'b1;
                            state       <= WB;
                        end else begin
                            imem_req_r <= 1'b1;
                            wait_cnt   <= '0;
                            state      <= FETCH;
                        end
                    end else if (timeout_hit) begin
                        dmem_req_r  <= 1'b0;
                        dmem_we_r   <= 1'b0;
                        bus_error_r <= 1'b1;
                        halted_r    <= 1'b1;
                        state       <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                WB: begin
                    imem_req_r <= 1'b1;
                    wait_cnt   <= '0;
                    state      <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.imem_req    = imem_req_r;
    assign bus.dmem_req    = dmem_req_r;
    assign bus.dmem_we     = dmem_we_r;
    assign bus.ir_write    = ir_write_r;
    assign bus.opcode_ULA  = opcode_r;
    assign bus.alu_src_imm = alu_src_imm_r;
    assign bus.reg_write   = reg_write_r;
    assign bus.reg_dst_rd  = reg_dst_rd_r;
    assign bus.mem_to_reg  = mem_to_reg_r;
    // A taken branch updates the PC in the EXEC cycle that sees zero.
    assign bus.pc_write    = pc_write_r | branch_taken;
    assign bus.pc_src      = branch_taken ? 2'b01 : pc_src_r;
    assign bus.halted      = halted_r;
    assign bus.illegal     = illegal_r;
    assign bus.bus_error   = bus_error_r;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with ACK_TIMEOUT=4; follows the macro build of the RTL.
module tb_mc_control_fsm;
    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    mc_control_fsm_if bus();

    mc_control_fsm #(.ACK_TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] funct);
        return {op, 5'd1, 5'd2, 5'd3, 6'd0, funct};
    endfunction

    function automatic logic [31:0] outs();
        return {13'd0, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_write,
                bus.opcode_ULA, bus.alu_src_imm, bus.reg_write, bus.reg_dst_rd,
                bus.mem_to_reg, bus.pc_write, bus.pc_src, bus.halted,
                bus.illegal, bus.bus_error};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Ack in the current FETCH cycle; returns in the DECODE cycle.
    task automatic fetch(input logic [31:0] word);
        bus.instr    = word;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        bus.instr    = ~word;
        check("fetch_ir_write", 32'(bus.ir_write), 32'd1);
    endtask

    initial begin
        int cnt;
        reset        = 1'b0;
        bus.instr    = '0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.zero     = 1'b0;
        #1 reset = 1'b1;
        #1 check("reset_outs", outs(), 32'd0);
        repeat (2) tick();
        check("reset_hold", outs(), 32'd0);
        reset        = 1'b0;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        check("arm_imem_req", 32'(bus.imem_req), 32'd1);
        check("stray_ack_ignored", 32'(bus.ir_write), 32'd0);

        // R-type, funct 5'b00101
        fetch(mk(6'h00, 5'b00101));
        check("rtype_pc_write", 32'(bus.pc_write), 32'd1);
        check("rtype_pc_src", 32'(bus.pc_src), 32'd0);
        tick();
        check("rtype_opcode", 32'(bus.opcode_ULA), 32'h05);
        check("rtype_imm", 32'(bus.alu_src_imm), 32'd0);
        check("rtype_dst_rd", 32'(bus.reg_dst_rd), 32'd1);
        check("rtype_no_wr_exec", 32'(bus.reg_write), 32'd0);
        tick();
        check("rtype_reg_write_c4", 32'(bus.reg_write), 32'd1);
        tick();
        check("rtype_imem_req_c5", 32'(bus.imem_req), 32'd1);
        check("rtype_wr_pulse_end", 32'(bus.reg_write), 32'd0);

        // Load with dmem_ack in the fourth MEM cycle
        fetch(mk(6'h02, 5'd0));
        tick();
        check("load_opcode", 32'(bus.opcode_ULA), 32'h04);
        check("load_imm", 32'(bus.alu_src_imm), 32'd1);
        check("load_dst_rt", 32'(bus.reg_dst_rd), 32'd0);
        tick();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.dmem_req && !bus.dmem_we) cnt++;
            if (i == 3) bus.dmem_ack = 1'b1;
            tick();
            bus.dmem_ack = 1'b0;
        end
        check("load_mem_cycles", 32'(cnt), 32'd4);
        check("load_req_drop", 32'(bus.dmem_req), 32'd0);
        check("load_reg_write", 32'(bus.reg_write), 32'd1);
        check("load_mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
        tick();
        check("load_refetch_c9", 32'(bus.imem_req), 32'd1);

        // beq taken
        fetch(mk(6'h04, 5'd0));
        tick();
        bus.zero = 1'b1;
        #1;
        check("beq_opcode", 32'(bus.opcode_ULA), 32'h10);
        check("beq_taken_pc_write", 32'(bus.pc_write), 32'd1);
        check("beq_taken_pc_src", 32'(bus.pc_src), 32'd1);
        tick();
        bus.zero = 1'b0;
        check("beq_taken_refetch", 32'(bus.imem_req), 32'd1);

        // beq not taken
        fetch(mk(6'h04, 5'd0));
        tick();
        #1;
        check("beq_not_taken_pc_write", 32'(bus.pc_write), 32'd0);
        tick();
        check("beq_not_taken_refetch", 32'(bus.imem_req), 32'd1);

        // bne taken
        fetch(mk(6'h05, 5'd0));
        tick();
        bus.zero = 1'b1;
        #1;
        check("bne_opcode", 32'(bus.opcode_ULA), 32'h11);
        check("bne_pc_write", 32'(bus.pc_write), 32'd1);
        tick();
        bus.zero = 1'b0;

        // Store with zero-wait ack
        fetch(mk(6'h03, 5'd0));
        tick();
        tick();
        check("store_dmem_req", 32'(bus.dmem_req), 32'd1);
        check("store_dmem_we", 32'(bus.dmem_we), 32'd1);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        check("store_refetch_c5", 32'(bus.imem_req), 32'd1);
        check("store_no_reg_write", 32'(bus.reg_write), 32'd0);
        check("store_req_drop", 32'(bus.dmem_req), 32'd0);

        // Jump
        fetch(mk(6'h06, 5'd0));
        tick();
        check("jump_refetch_c3", 32'(bus.imem_req), 32'd1);
        check("jump_pc_write", 32'(bus.pc_write), 32'd1);
        check("jump_pc_src", 32'(bus.pc_src), 32'd2);

        // I-type ALU op 6'h3E
        fetch(mk(6'h3E, 5'd0));
        tick();
        check("itype_opcode", 32'(bus.opcode_ULA), 32'h1E);
        check("itype_imm", 32'(bus.alu_src_imm), 32'd1);
        check("itype_dst_rt", 32'(bus.reg_dst_rd), 32'd0);
        check("itype_legal", 32'(bus.illegal), 32'd0);
        tick();
        check("itype_reg_write", 32'(bus.reg_write), 32'd1);
        tick();

        // imem_ack arriving on the expiry cycle
        bus.instr = mk(6'h00, 5'd7);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.imem_ack = 1'b1;
            tick();
            bus.imem_ack = 1'b0;
        end
        check("expiry_ack_no_error", 32'(bus.bus_error), 32'd0);
        check("expiry_ack_ir_write", 32'(bus.ir_write), 32'd1);
        tick();
        check("expiry_ack_opcode", 32'(bus.opcode_ULA), 32'h07);
        tick();
        tick();

        // imem_ack held low: timeout after 4 wait cycles
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.imem_req) cnt++;
            tick();
        end
        check("timeout_req_cycles", 32'(cnt), 32'd4);
        check("timeout_bus_error", 32'(bus.bus_error), 32'd1);
        check("timeout_halted", 32'(bus.halted), 32'd1);
        check("timeout_req_drop", 32'(bus.imem_req), 32'd0);
        tick();
        check("halt_terminal", 32'(bus.halted), 32'd1);

        // Reset out of HALT, then reset in the middle of MEM
        reset = 1'b1;
        #1 check("reset_clears_sticky", outs(), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rearm_after_halt", 32'(bus.imem_req), 32'd1);
        fetch(mk(6'h02, 5'd0));
        tick();
        tick();
        check("mid_mem_dmem_req", 32'(bus.dmem_req), 32'd1);
        reset = 1'b1;
        #1 check("mid_mem_reset_outs", outs(), 32'd0);
        tick();
        check("mid_mem_reset_no_strobe", outs(), 32'd0);
        reset = 1'b0;
        tick();
        check("mid_mem_rearm", 32'(bus.imem_req), 32'd1);
        check("mid_mem_sticky_clear", 32'({bus.halted, bus.illegal, bus.bus_error}), 32'd0);

        // Undefined opcode 6'h1F
        fetch(mk(6'h1F, 5'd0));
        tick();
        check("illegal_flag", 32'(bus.illegal), 32'd1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        check("illegal_trap_halted", 32'(bus.halted), 32'd1);
        check("illegal_trap_no_req", 32'(bus.imem_req), 32'd0);
`else
        check("illegal_nop_not_halted", 32'(bus.halted), 32'd0);
        check("illegal_nop_refetch", 32'(bus.imem_req), 32'd1);
        check("illegal_nop_no_strobes", 32'({bus.pc_write, bus.reg_write, bus.dmem_req}), 32'd0);
        fetch(mk(6'h00, 5'd3));
        tick();
        check("illegal_next_opcode", 32'(bus.opcode_ULA), 32'h03);
        check("illegal_sticky", 32'(bus.illegal), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle control unit that drives the ALU's `opcode_ULA` / `zero` interface from the producer side. It fetches a 32-bit instruction over a req/ack port and decodes it into the 5-bit ALU operation code plus datapath strobes. It then sequences FETCH/DECODE/EXEC/MEM/WB, consuming the ALU `zero` flag for branches. It sits between instruction/data memory handshakes and the register file / ALU / PC datapath of the multicycle MIPS variant.

## Interface
- `ACK_TIMEOUT`, default 255: maximum number of cycles to wait for `imem_ack`/`dmem_ack`. 0 disables the timeout.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `instr` in 32: instruction word, valid when `imem_ack`=1.
- `imem_ack` in 1: instruction memory acknowledge.
- `dmem_ack` in 1: data memory acknowledge.
- `zero` in 1: ALU condition flag; 1 means the compare condition is true.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: 1 = store, 0 = load; valid with `dmem_req`.
- `ir_write` out 1: latch `instr` into the datapath IR.
- `opcode_ULA` out 5: ALU operation code.
- `alu_src_imm` out 1: 1 = ALU B operand is the sign-extended immediate.
- `reg_write` out 1: register file write strobe.
- `reg_dst_rd` out 1: 1 = destination `rd`, 0 = destination `rt`.
- `mem_to_reg` out 1: 1 = writeback data comes from memory.
- `pc_write` out 1: PC load strobe.
- `pc_src` out 2: 00 = PC+1, 01 = branch target, 10 = jump target.
- `halted` out 1: core stopped.
- `illegal` out 1: sticky, set on an undefined opcode.
- `bus_error` out 1: sticky, set on an ack timeout.

## Operation
- Instruction fields:
  - `op` = `instr[31:26]`; `rs` = [25:21]; `rt` = [20:16]; `rd` = [15:11]; `funct` = [4:0].
  - The IR copy is captured internally on `ir_write`.
- Decode (`opcode_ULA` is registered in DECODE and held until the next DECODE):
  - `op` 6'h00, R-type: `opcode_ULA`=`funct`; imm=0; write `rd`.
  - `op`[5]=1, I-type ALU: `opcode_ULA`=`op[4:0]`; imm=1; write `rt`.
  - 6'h02 load: opcode 5'b00100; imm=1; MEM read; write `rt` from memory.
  - 6'h03 store: opcode 5'b00100; imm=1; MEM write; no writeback.
  - 6'h04 beq: opcode 5'b10000. 6'h05 bne: opcode 5'b10001. Both use imm=0 and branch when `zero`=1.
  - 6'h06 jump: `opcode_ULA`=0.
  - 6'h07 halt: go to HALT.
  - Any other `op` is illegal.
- States and transitions:
  - FETCH: `imem_req`=1 until `imem_ack`. On ack: `ir_write`=1, `pc_write`=1, `pc_src`=00, next DECODE.
  - DECODE: set the decode registers. Jump: `pc_write`=1, `pc_src`=10, next FETCH. Halt: next HALT. Otherwise next EXEC.
  - EXEC:
    - Branch: if `zero`=1, `pc_write`=1 and `pc_src`=01; next FETCH.
    - Load/store: next MEM.
    - ALU: next WB.
  - MEM: `dmem_req`=1 (`dmem_we` per class) until `dmem_ack`. On ack, load goes to WB and store goes to FETCH.
  - WB: `reg_write`=1 for one cycle; next FETCH.
  - HALT: terminal; `halted`=1 until reset.
- Strobes:
  - `ir_write`, `pc_write` and `reg_write` are single-cycle pulses.
  - `imem_req`, `dmem_req` and `dmem_we` are level signals held until their ack.
- Ack handling:
  - An ack is ignored while the matching request is low.
  - An ack that arrives in the same cycle as the timeout expiry wins; no error is raised.
- Timeout:
  - A wait counter clears on entry to FETCH/MEM and increments on each cycle without ack.
  - When the count reaches `ACK_TIMEOUT` (if nonzero): `bus_error`=1, next HALT, and the request drops.

## Timing
- Reset values: all outputs 0; state = FETCH; counter = 0.
- `imem_req`=1 on the first clock edge after `reset` is deasserted.
- All outputs are registered / state-decoded with no combinational path from `instr`. Exceptions: `zero` and the acks, which are sampled in the same cycle.
- Minimum cycles per instruction with a zero-wait ack (ack in the first request cycle):
  - ALU: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Jump: 2.
- Each ack wait cycle adds 1.
- Reset asserted mid-instruction:
  - Outputs return to their reset values immediately (asynchronously), including the sticky flags.
  - In-flight requests are abandoned and no strobe is emitted.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined: an illegal opcode in DECODE sets `illegal`=1 and goes to HALT.
- Not defined: an illegal opcode is treated as a NOP. `illegal`=1 (sticky), then FETCH, with no strobes.

## Test plan
- After reset, `instr`=R-type with `funct`=5'b00101, ack in the first cycle:
  - `opcode_ULA`=5'b00101 in EXEC, `alu_src_imm`=0, `reg_dst_rd`=1.
  - `reg_write` pulses in cycle 4; `imem_req` is high again in cycle 5.
- Load with `dmem_ack` delayed 3 cycles:
  - `dmem_req`=1 and `dmem_we`=0 for 4 cycles.
  - `mem_to_reg`=1 with a `reg_write` pulse; total 8 cycles.
- beq with `zero`=1, then with `zero`=0:
  - `zero`=1: `pc_write` with `pc_src`=01 in EXEC.
  - `zero`=0: no `pc_write` in EXEC; FETCH after 3 cycles.
- `ACK_TIMEOUT`=4, `imem_ack` held low:
  - `bus_error`=1 and `halted`=1 after 4 wait cycles; `imem_req` drops.
  - Repeat with the ack arriving on the expiry cycle: no error.
- `op`=6'h3E is legal (I-type ALU, `opcode_ULA`=5'b11110); `op`=6'h1F is illegal:
  - With `MC_CTRL_ILLEGAL_TRAP_EN`: `halted`=1.
  - Without it: `illegal`=1 and the next fetch proceeds.
- Assert `reset` during MEM:
  - All outputs are 0 the same cycle.
  - After release, `imem_req`=1 and the sticky flags are cleared.
